// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the MEM-stage data responder.
package data_mem_pkg;
   typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_DONE} mem_state_t;
   localparam int WORD_WIDTH = 32;
endpackage

// File: rtl/data_memory_responder_if.sv
// CPU MEM-stage data port: request from the CPU, data/stall/err back from memory.
interface data_memory_responder_if
   import data_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] address;
   logic [WORD_WIDTH-1:0] data_in;
   logic                  read;
   logic                  write;
   logic [WORD_WIDTH-1:0] data_out;
   logic                  stall;
   logic                  err;

   modport master (output address, data_in, read, write, input data_out, stall, err);
   modport slave  (input address, data_in, read, write, output data_out, stall, err);
endinterface

// File: rtl/data_memory_responder_sram_1p.sv
// Single-port word RAM, synchronous read, contents not reset.
module sram_1p #(
   parameter int DEPTH_LOG2 = 10,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [WORD_WIDTH-1:0] wdata,
   output logic [WORD_WIDTH-1:0] rdata
);
   logic [WORD_WIDTH-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder: accepts one request in IDLE, holds stall for LATENCY
// wait states, performs the RAM access, then releases the CPU for one DONE cycle.
module data_memory_responder
   import data_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   data_memory_responder_if.slave bus
);
   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("data_memory_responder: LATENCY must be within 1..15");
   end

   mem_state_t            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] addr_q, addr_d;
   logic [WORD_WIDTH-1:0] wdat_q, wdat_d;
   logic                  wr_q, wr_d;
   logic [WORD_WIDTH-1:0] dout_q, dout_d;
   logic [WORD_WIDTH-1:0] rdata;
   logic                  req, oor, we;

   assign req = bus.read | bus.write;
   assign oor = |bus.address[ADDR_WIDTH-1:DEPTH_LOG2];
   assign we  = (state_q == MEM_BUSY) && (cnt_q == 4'd0) && wr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      wr_d    = wr_q;
      dout_d  = dout_q;
      case (state_q)
         MEM_IDLE: if (req) begin
            addr_d  = bus.address[DEPTH_LOG2-1:0];
            wdat_d  = bus.data_in;
            wr_d    = bus.write;
            cnt_d   = 4'(LATENCY - 1);
            state_d = MEM_BUSY;
         end
         MEM_BUSY: begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = MEM_DONE;
         end
         MEM_DONE: begin
            // rdata is valid throughout DONE; latch it so data_out holds afterwards
            if (!wr_q) dout_d = rdata;
            state_d = MEM_IDLE;
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MEM_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdat_q  <= '0;
         wr_q    <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         wr_q    <= wr_d;
         dout_q  <= dout_d;
      end
   end

   sram_1p #(.DEPTH_LOG2(DEPTH_LOG2), .WORD_WIDTH(WORD_WIDTH)) u_ram (
      .clk   (clk),
      .we    (we),
      .addr  (addr_q),
      .wdata (wdat_q),
      .rdata (rdata)
   );

   // Outputs gated by rst_n so stall/err drop asynchronously with reset.
   assign bus.stall    = rst_n & (((state_q == MEM_IDLE) & req) | (state_q == MEM_BUSY));
   assign bus.err      = rst_n & (state_q == MEM_IDLE) & req & (oor | (bus.read & bus.write));
   assign bus.data_out = (state_q == MEM_DONE && !wr_q) ? rdata : dout_q;

   a_no_stall_in_done: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == MEM_DONE) |-> !bus.stall);
   a_single_write: assert property (@(posedge clk) disable iff (!rst_n)
      we |=> !we);
   a_dout_stable: assert property (@(posedge clk) disable iff (!rst_n)
      !(state_q == MEM_DONE && !wr_q) |-> $stable(bus.data_out));
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (LATENCY=2, DEPTH_LOG2=10).
module tb_data_memory_responder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   comps = 0;
   int   fails = 0;
   int   cyc = 0;

   data_memory_responder_if #(.ADDR_WIDTH(16)) bus ();

   data_memory_responder #(.ADDR_WIDTH(16), .DEPTH_LOG2(10), .LATENCY(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Presents one request at a negedge and follows it until the first stall=0 cycle.
   task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d,
                         output int nstall, output logic [31:0] dout, output int nerr, output int start);
      @(negedge clk);
      bus.read = rd; bus.write = wr; bus.address = a; bus.data_in = d;
      start = cyc;
      #1;
      nstall = 0;
      nerr = 0;
      while (bus.stall === 1'b1 && nstall < 20) begin
         if (bus.err === 1'b1) nerr++;
         nstall++;
         @(negedge clk); #1;
      end
      if (bus.err === 1'b1) nerr++;
      dout = bus.data_out;
      bus.read = 1'b0; bus.write = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      bus.read = 1'b1; bus.write = 1'b0; bus.address = 16'd5; bus.data_in = '0;
      rst_n = 1'b0;
      #12;
      comps++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b exp 0", bus.stall); end
      comps++; if (bus.data_out !== 32'h0) begin fails++; $display("FAIL reset_dout: got %h exp 0", bus.data_out); end
      comps++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b exp 0", bus.err); end
      @(negedge clk); rst_n = 1'b1; #1;
      comps++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL reset_release_stall: got %b exp 1", bus.stall); end
      n = 0;
      while (bus.stall === 1'b1 && n < 20) begin n++; @(negedge clk); #1; end
      comps++; if (n != 3) begin fails++; $display("FAIL reset_first_access_stall: got %0d exp 3", n); end
      bus.read = 1'b0;
   endtask

   task automatic test_write_read();
      int ns, ne, st;
      logic [31:0] dv;
      access(1'b0, 1'b1, 16'd5, 32'hDEADBEEF, ns, dv, ne, st);
      comps++; if (ns != 3) begin fails++; $display("FAIL wr_stall_cycles: got %0d exp 3", ns); end
      comps++; if (ne != 0) begin fails++; $display("FAIL wr_err: got %0d exp 0", ne); end
      access(1'b1, 1'b0, 16'd5, 32'h0, ns, dv, ne, st);
      comps++; if (ns != 3) begin fails++; $display("FAIL rd_stall_cycles: got %0d exp 3", ns); end
      comps++; if (dv !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h exp deadbeef", dv); end
      @(negedge clk); #1;
      comps++; if (bus.data_out !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data_hold: got %h exp deadbeef", bus.data_out); end
      comps++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL idle_stall: got %b exp 0", bus.stall); end
   endtask

   task automatic test_back_to_back();
      int ns, ne, st, prev;
      logic [31:0] dv;
      logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
      prev = -1;
      for (int i = 0; i < 3; i++) begin
         access(1'b0, 1'b1, 16'(i), vals[i], ns, dv, ne, st);
         if (prev >= 0) begin
            comps++; if (st - prev != 4) begin fails++; $display("FAIL b2b_wr_spacing%0d: got %0d exp 4", i, st - prev); end
         end
         prev = st;
      end
      for (int i = 0; i < 3; i++) begin
         access(1'b1, 1'b0, 16'(i), 32'h0, ns, dv, ne, st);
         comps++; if (st - prev != 4) begin fails++; $display("FAIL b2b_rd_spacing%0d: got %0d exp 4", i, st - prev); end
         comps++; if (dv !== vals[i]) begin fails++; $display("FAIL b2b_rd_data%0d: got %h exp %h", i, dv, vals[i]); end
         prev = st;
      end
   endtask

   task automatic test_out_of_range();
      int ns, ne, st;
      logic [31:0] dv;
      access(1'b0, 1'b1, 16'h0403, 32'hA5, ns, dv, ne, st);
      comps++; if (ne != 1) begin fails++; $display("FAIL oor_err_pulses: got %0d exp 1", ne); end
      comps++; if (ns != 3) begin fails++; $display("FAIL oor_stall_cycles: got %0d exp 3", ns); end
      access(1'b1, 1'b0, 16'h0003, 32'h0, ns, dv, ne, st);
      comps++; if (dv !== 32'hA5) begin fails++; $display("FAIL oor_wrap_data: got %h exp a5", dv); end
      comps++; if (ne != 0) begin fails++; $display("FAIL inrange_err: got %0d exp 0", ne); end
   endtask

   task automatic test_read_write_both();
      int ns, ne, st;
      logic [31:0] dv;
      access(1'b1, 1'b1, 16'd7, 32'h77, ns, dv, ne, st);
      comps++; if (ne != 1) begin fails++; $display("FAIL rw_err_pulses: got %0d exp 1", ne); end
      comps++; if (dv !== 32'hA5) begin fails++; $display("FAIL rw_dout_unchanged: got %h exp a5", dv); end
      access(1'b1, 1'b0, 16'd7, 32'h0, ns, dv, ne, st);
      comps++; if (dv !== 32'h77) begin fails++; $display("FAIL rw_readback: got %h exp 77", dv); end
   endtask

   task automatic test_reset_busy();
      int ns, ne, st;
      logic [31:0] dv;
      access(1'b0, 1'b1, 16'd9, 32'h12, ns, dv, ne, st);
      @(negedge clk);
      bus.write = 1'b1; bus.read = 1'b0; bus.address = 16'd9; bus.data_in = 32'h99;
      @(negedge clk); #1;
      comps++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL busy_stall: got %b exp 1", bus.stall); end
      rst_n = 1'b0; #1;
      comps++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rst_busy_stall: got %b exp 0", bus.stall); end
      comps++; if (bus.data_out !== 32'h0) begin fails++; $display("FAIL rst_busy_dout: got %h exp 0", bus.data_out); end
      bus.write = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      access(1'b1, 1'b0, 16'd9, 32'h0, ns, dv, ne, st);
      comps++; if (dv !== 32'h12) begin fails++; $display("FAIL rst_discard_write: got %h exp 12", dv); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_out_of_range();
      test_read_write_both();
      test_reset_busy();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
      $finish;
   end
endmodule
